ten_bit_register_file_reader: RTL

Dual-port registered read unit over an 8-entry bank of 10-bit registers. It is the read side of the CPU register storage: one write port loads entries, and two independent read ports return entries one cycle later with a valid strobe. The block sits between instruction decode, which supplies the read addresses, and the ALU operand latches, which consume `qa`/`qb`. Same-cycle write-to-read forwarding is a build-time option.

---
 rtl/ten_bit_register_file_reader.sv | 55 +++++
 1 files changed

// File: rtl/ten_bit_register_file_reader.sv
// ten_bit_register_file_reader: 8x10 register bank with two registered read ports; REGFILE_BYPASS_EN forwards same-cycle writes.
module ten_bit_register_file_reader #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter logic [WIDTH-1:0] INIT = 10'b1111100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  d,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  qa,
  output logic              va,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  qb,
  output logic              vb
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_a, rd_b;
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_a = (w && waddr == raddr_a) ? d : mem[raddr_a];
    rd_b = (w && waddr == raddr_b) ? d : mem[raddr_b];
  end
`else
  always_comb begin
    rd_a = mem[raddr_a];
    rd_b = mem[raddr_b];
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (w) begin
      mem[waddr] <= d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa <= '0;
      va <= 1'b0;
      qb <= '0;
      vb <= 1'b0;
    end else begin
      qa <= re_a ? rd_a : qa;
      va <= re_a;
      qb <= re_b ? rd_b : qb;
      vb <= re_b;
    end
  end
endmodule
